fourbit_execute: RTL and testbench

- Execute stage directly downstream of the 4-bit processor's instruction-select stage.
- Consumes one decoded 4-bit opcode plus operand fields per transaction over a valid/ready handshake.
- Operates on four 4-bit accumulators and a 4-bit flag register, and reports completion.
- Most ops take one execute cycle; MUL is iterative shift-add over 4 cycles; HALT parks the stage until reset.

---
 rtl/fourbit_execute.sv | 263 ++++++++++++++++++++++++++
 tb/tb_fourbit_execute.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fourbit_execute.sv
// Execute stage of the 4-bit processor: four accumulators, a Z/C/N/V flag register,
// single-cycle ALU ops, a 4-iteration shift-add multiplier and a sticky HALT state.
module fourbit_execute #(
    parameter int MUL_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       op_valid,
    output logic       op_ready,
    input  logic [3:0] op_code,
    input  logic [1:0] op_dst,
    input  logic [1:0] op_src,
    input  logic [3:0] op_imm,
    output logic [3:0] accum1_o,
    output logic [3:0] accum2_o,
    output logic [3:0] accum3_o,
    output logic [3:0] accum4_o,
    output logic [3:0] flag_o,
    output logic       done,
    output logic       busy,
    output logic       halted
);

    localparam int DATA_W = 4;
    localparam int ITER_W = $clog2(MUL_CYCLES + 1);
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(MUL_CYCLES);

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LDI  = 4'd1;
    localparam logic [3:0] OP_MOV  = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_NOT  = 4'd8;
    localparam logic [3:0] OP_SHL  = 4'd9;
    localparam logic [3:0] OP_SHR  = 4'd10;
    localparam logic [3:0] OP_INC  = 4'd11;
    localparam logic [3:0] OP_DEC  = 4'd12;
    localparam logic [3:0] OP_CMP  = 4'd13;
    localparam logic [3:0] OP_MUL  = 4'd14;
    localparam logic [3:0] OP_HALT = 4'd15;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        MUL,
        HALT
    } state_t;

    state_t state, state_next;

    logic [DATA_W-1:0] accum [4];
    logic [3:0]        flags;
    logic [3:0]        flags_next;
    logic              halt_pulsed;
    logic [ITER_W-1:0] mul_iter;

    logic [3:0]        code_p0;
    logic [1:0]        dst_p0;
    logic [DATA_W-1:0] imm_p0;
    logic [DATA_W-1:0] dst_val_p0;
    logic [DATA_W-1:0] src_val_p0;

    logic [2*DATA_W-1:0] prod_p1;
    logic [2*DATA_W-1:0] mcand_p1;
    logic [DATA_W-1:0]   mplier_p1;

    logic              accept;
    logic              mul_step;
    logic              retire;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] res;
    logic              c_new;
    logic              v_new;
    logic              wr_en;
    logic              upd_zn;

    // Two's-complement overflow: the 5-bit signed result leaves the 4-bit range
    // exactly when its top two bits disagree.
    function automatic logic add_ovf(input logic signed [DATA_W-1:0] x,
                                     input logic signed [DATA_W-1:0] y);
        logic signed [DATA_W:0] sum;
        sum = (DATA_W+1)'(x) + (DATA_W+1)'(y);
        return sum[DATA_W] ^ sum[DATA_W-1];
    endfunction

    function automatic logic sub_ovf(input logic signed [DATA_W-1:0] x,
                                     input logic signed [DATA_W-1:0] y);
        logic signed [DATA_W:0] diff;
        diff = (DATA_W+1)'(x) - (DATA_W+1)'(y);
        return diff[DATA_W] ^ diff[DATA_W-1];
    endfunction

    assign accept   = op_valid && op_ready;
    assign mul_step = (mul_iter != ITER_LAST);
    assign retire   = (state == EXEC) || ((state == MUL) && !mul_step);

    always_comb begin
        state_next = state;
        op_ready   = 1'b0;
        busy       = 1'b0;
        halted     = 1'b0;
        case (state)
            IDLE: begin
                op_ready = !rst;
                if (op_valid && !rst) begin
                    case (op_code)
                        OP_MUL:  state_next = MUL;
                        OP_HALT: state_next = HALT;
                        default: state_next = EXEC;
                    endcase
                end
            end
            EXEC: begin
                busy       = 1'b1;
                state_next = IDLE;
            end
            MUL: begin
                busy = 1'b1;
                if (!mul_step) state_next = IDLE;
            end
            HALT: begin
                halted = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        a      = dst_val_p0;
        b      = src_val_p0;
        res    = a;
        c_new  = flags[FLAG_C];
        v_new  = flags[FLAG_V];
        wr_en  = 1'b0;
        upd_zn = 1'b0;
        case (code_p0)
            OP_LDI: begin res = imm_p0; wr_en = 1'b1; upd_zn = 1'b1; end
            OP_MOV: begin res = b;      wr_en = 1'b1; upd_zn = 1'b1; end
            OP_ADD: begin
                {c_new, res} = {1'b0, a} + {1'b0, b};
                v_new  = add_ovf(a, b);
                wr_en  = 1'b1;
                upd_zn = 1'b1;
            end
            OP_SUB, OP_CMP: begin
                res    = a - b;
                c_new  = (a < b);
                v_new  = sub_ovf(a, b);
                wr_en  = (code_p0 == OP_SUB);
                upd_zn = 1'b1;
            end
            OP_AND: begin res = a & b; wr_en = 1'b1; upd_zn = 1'b1; end
            OP_OR:  begin res = a | b; wr_en = 1'b1; upd_zn = 1'b1; end
            OP_XOR: begin res = a ^ b; wr_en = 1'b1; upd_zn = 1'b1; end
            OP_NOT: begin res = ~b;    wr_en = 1'b1; upd_zn = 1'b1; end
            OP_SHL: begin
                res    = {a[DATA_W-2:0], 1'b0};
                c_new  = a[DATA_W-1];
                wr_en  = 1'b1;
                upd_zn = 1'b1;
            end
            OP_SHR: begin
                res    = {1'b0, a[DATA_W-1:1]};
                c_new  = a[0];
                wr_en  = 1'b1;
                upd_zn = 1'b1;
            end
            OP_INC: begin
                res    = a + 4'd1;
                c_new  = (a == 4'hF);
                v_new  = add_ovf(a, 4'd1);
                wr_en  = 1'b1;
                upd_zn = 1'b1;
            end
            OP_DEC: begin
                res    = a - 4'd1;
                c_new  = (a == 4'h0);
                v_new  = sub_ovf(a, 4'd1);
                wr_en  = 1'b1;
                upd_zn = 1'b1;
            end
            OP_MUL: begin
                res    = prod_p1[DATA_W-1:0];
                c_new  = |prod_p1[2*DATA_W-1:DATA_W];
                v_new  = 1'b0;
                wr_en  = 1'b1;
                upd_zn = 1'b1;
            end
            default: ;
        endcase

        flags_next = flags;
        if (upd_zn) begin
            flags_next[FLAG_Z] = (res == '0);
            flags_next[FLAG_N] = res[DATA_W-1];
        end
        flags_next[FLAG_C] = c_new;
        flags_next[FLAG_V] = v_new;
    end

    // p0: operand capture on acceptance; p1: shift-add multiplier datapath
    always_ff @(posedge clk) begin
        if (accept) begin
            code_p0    <= op_code;
            dst_p0     <= op_dst;
            imm_p0     <= op_imm;
            dst_val_p0 <= accum[op_dst];
            src_val_p0 <= accum[op_src];
            prod_p1    <= '0;
            mcand_p1   <= {{DATA_W{1'b0}}, accum[op_dst]};
            mplier_p1  <= accum[op_src];
        end else if ((state == MUL) && mul_step) begin
            if (mplier_p1[0]) prod_p1 <= prod_p1 + mcand_p1;
            mcand_p1  <= mcand_p1 << 1;
            mplier_p1 <= mplier_p1 >> 1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            flags       <= '0;
            done        <= 1'b0;
            halt_pulsed <= 1'b0;
            mul_iter    <= '0;
            for (int i = 0; i < 4; i++) accum[i] <= '0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            if (accept) begin
                mul_iter <= '0;
            end else if ((state == MUL) && mul_step) begin
                mul_iter <= mul_iter + 1'b1;
            end
            if (retire) begin
                done  <= 1'b1;
                flags <= flags_next;
                if (wr_en) accum[dst_p0] <= res;
            end
            // HALT retires once, then stays silent until reset
            if ((state == HALT) && !halt_pulsed) begin
                done        <= 1'b1;
                halt_pulsed <= 1'b1;
            end
        end
    end

    assign accum1_o = accum[0];
    assign accum2_o = accum[1];
    assign accum3_o = accum[2];
    assign accum4_o = accum[3];
    assign flag_o   = flags;

endmodule

// File: tb/tb_fourbit_execute.sv
// Directed self-checking bench for fourbit_execute.
module tb_fourbit_execute;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LDI  = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd8;
    localparam logic [3:0] OP_SHL  = 4'd9;
    localparam logic [3:0] OP_INC  = 4'd11;
    localparam logic [3:0] OP_DEC  = 4'd12;
    localparam logic [3:0] OP_CMP  = 4'd13;
    localparam logic [3:0] OP_MUL  = 4'd14;
    localparam logic [3:0] OP_HALT = 4'd15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       op_valid = 1'b0;
    logic       op_ready;
    logic [3:0] op_code = '0;
    logic [1:0] op_dst = '0;
    logic [1:0] op_src = '0;
    logic [3:0] op_imm = '0;
    logic [3:0] accum1_o, accum2_o, accum3_o, accum4_o, flag_o;
    logic       done, busy, halted;

    int checks = 0;
    int errors = 0;

    fourbit_execute dut (
        .clk      (clk),
        .rst      (rst),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op_code  (op_code),
        .op_dst   (op_dst),
        .op_src   (op_src),
        .op_imm   (op_imm),
        .accum1_o (accum1_o),
        .accum2_o (accum2_o),
        .accum3_o (accum3_o),
        .accum4_o (accum4_o),
        .flag_o   (flag_o),
        .done     (done),
        .busy     (busy),
        .halted   (halted)
    );

    always #10 clk = ~clk;

    task automatic do_reset;
        @(negedge clk);
        op_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Issue one op, return cycles from accept edge to done and cycles op_ready was low.
    task automatic do_op(input logic [3:0] c, input logic [1:0] d, input logic [1:0] s,
                         input logic [3:0] i, output int lat, output int rlow);
        int n;
        @(negedge clk);
        op_code = c; op_dst = d; op_src = s; op_imm = i; op_valid = 1'b1;
        n = 0;
        while (op_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        op_valid = 1'b0;
        lat = -1;
        rlow = 0;
        if (op_ready !== 1'b1) rlow++;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                lat = k;
                break;
            end
            if (op_ready !== 1'b1) rlow++;
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({accum1_o, accum2_o, accum3_o, accum4_o, flag_o, done, busy, halted} !== 23'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h required 0",
                     {accum1_o, accum2_o, accum3_o, accum4_o, flag_o, done, busy, halted});
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (op_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b required 1", op_ready);
        end
    endtask

    task automatic test_add;
        int lat, rl;
        do_reset();
        do_op(OP_LDI, 2'd0, 2'd0, 4'd9, lat, rl);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL ldi_latency got %0d required 1", lat); end
        do_op(OP_LDI, 2'd1, 2'd0, 4'd9, lat, rl);
        do_op(OP_ADD, 2'd0, 2'd1, 4'd0, lat, rl);
        checks++;
        if (lat !== 1 || accum1_o !== 4'h2) begin
            errors++;
            $display("FAIL add_result got lat=%0d a1=%h required lat=1 a1=2", lat, accum1_o);
        end
        checks++;
        if (flag_o !== 4'b1010) begin errors++; $display("FAIL add_flags got %b required 1010", flag_o); end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL done_width got %b required 0", done); end
    endtask

    task automatic test_sub_cmp;
        int lat, rl;
        do_reset();
        do_op(OP_LDI, 2'd0, 2'd0, 4'd3, lat, rl);
        do_op(OP_LDI, 2'd1, 2'd0, 4'd5, lat, rl);
        do_op(OP_SUB, 2'd0, 2'd1, 4'd0, lat, rl);
        checks++;
        if (accum1_o !== 4'hE || flag_o !== 4'b0110) begin
            errors++;
            $display("FAIL sub got a1=%h f=%b required a1=e f=0110", accum1_o, flag_o);
        end
        do_op(OP_CMP, 2'd1, 2'd1, 4'd0, lat, rl);
        checks++;
        if (flag_o !== 4'b0001 || accum2_o !== 4'h5 || accum1_o !== 4'hE) begin
            errors++;
            $display("FAIL cmp got f=%b a2=%h a1=%h required f=0001 a2=5 a1=e", flag_o, accum2_o, accum1_o);
        end
    endtask

    task automatic test_mul;
        int lat, rl;
        do_reset();
        do_op(OP_LDI, 2'd0, 2'd0, 4'd7, lat, rl);
        do_op(OP_LDI, 2'd1, 2'd0, 4'd3, lat, rl);
        do_op(OP_MUL, 2'd0, 2'd1, 4'd0, lat, rl);
        checks++;
        if (lat !== 5 || rl !== 5) begin
            errors++;
            $display("FAIL mul_timing got lat=%0d ready_low=%0d required 5 5", lat, rl);
        end
        checks++;
        if (accum1_o !== 4'h5 || flag_o !== 4'b0010) begin
            errors++;
            $display("FAIL mul_7x3 got a1=%h f=%b required a1=5 f=0010", accum1_o, flag_o);
        end
        do_op(OP_LDI, 2'd0, 2'd0, 4'd3, lat, rl);
        do_op(OP_LDI, 2'd1, 2'd0, 4'd5, lat, rl);
        do_op(OP_MUL, 2'd0, 2'd1, 4'd0, lat, rl);
        checks++;
        if (accum1_o !== 4'hF || flag_o !== 4'b0100) begin
            errors++;
            $display("FAIL mul_3x5 got a1=%h f=%b required a1=f f=0100", accum1_o, flag_o);
        end
    endtask

    task automatic test_back_to_back;
        int lat, rl, acc_k, d1, d2, nd;
        logic r;
        do_reset();
        do_op(OP_LDI, 2'd0, 2'd0, 4'd2, lat, rl);
        do_op(OP_LDI, 2'd1, 2'd0, 4'd6, lat, rl);
        @(negedge clk);
        op_code = OP_MUL; op_dst = 2'd0; op_src = 2'd1; op_valid = 1'b1;
        @(posedge clk); #1;
        op_code = OP_LDI; op_dst = 2'd2; op_imm = 4'd6;
        acc_k = -1; d1 = -1; d2 = -1; nd = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            r = op_ready;
            @(posedge clk); #1;
            if (r === 1'b1 && op_valid) begin
                acc_k = k;
                op_valid = 1'b0;
            end
            if (done === 1'b1) begin
                nd++;
                if (nd == 1) d1 = k;
                else if (nd == 2) d2 = k;
            end
        end
        op_valid = 1'b0;
        checks++;
        if (nd !== 2 || d1 !== 5 || acc_k !== 6 || d2 !== 7) begin
            errors++;
            $display("FAIL b2b_timing got dones=%0d d1=%0d acc=%0d d2=%0d required 2 5 6 7", nd, d1, acc_k, d2);
        end
        checks++;
        if (accum1_o !== 4'hC || accum3_o !== 4'h6 || flag_o !== 4'b0000) begin
            errors++;
            $display("FAIL b2b_values got a1=%h a3=%h f=%b required c 6 0000", accum1_o, accum3_o, flag_o);
        end
    endtask

    task automatic test_reset_mid_mul;
        int lat, rl, nd;
        do_reset();
        do_op(OP_LDI, 2'd0, 2'd0, 4'd7, lat, rl);
        do_op(OP_LDI, 2'd1, 2'd0, 4'd3, lat, rl);
        do_op(OP_LDI, 2'd3, 2'd0, 4'd9, lat, rl);
        @(negedge clk);
        op_code = OP_MUL; op_dst = 2'd0; op_src = 2'd1; op_valid = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({accum1_o, accum2_o, accum3_o, accum4_o, flag_o, done, busy, halted} !== 23'd0) begin
            errors++;
            $display("FAIL mid_mul_reset got %h required 0",
                     {accum1_o, accum2_o, accum3_o, accum4_o, flag_o, done, busy, halted});
        end
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) nd++;
        end
        checks++;
        if (nd !== 0 || accum1_o !== 4'h0) begin
            errors++;
            $display("FAIL mul_abort got dones=%0d a1=%h required 0 0", nd, accum1_o);
        end
        do_op(OP_LDI, 2'd3, 2'd0, 4'hA, lat, rl);
        checks++;
        if (accum4_o !== 4'hA || flag_o !== 4'b0100) begin
            errors++;
            $display("FAIL post_reset_ldi got a4=%h f=%b required a 0100", accum4_o, flag_o);
        end
    endtask

    task automatic test_boundaries;
        int lat, rl;
        do_reset();
        do_op(OP_LDI, 2'd0, 2'd0, 4'hF, lat, rl);
        do_op(OP_INC, 2'd0, 2'd0, 4'd0, lat, rl);
        checks++;
        if (accum1_o !== 4'h0 || flag_o !== 4'b0011) begin
            errors++;
            $display("FAIL inc_wrap got a1=%h f=%b required 0 0011", accum1_o, flag_o);
        end
        do_op(OP_LDI, 2'd0, 2'd0, 4'h7, lat, rl);
        do_op(OP_INC, 2'd0, 2'd0, 4'd0, lat, rl);
        checks++;
        if (accum1_o !== 4'h8 || flag_o !== 4'b1100) begin
            errors++;
            $display("FAIL inc_ovf got a1=%h f=%b required 8 1100", accum1_o, flag_o);
        end
        do_op(OP_DEC, 2'd0, 2'd0, 4'd0, lat, rl);
        checks++;
        if (accum1_o !== 4'h7 || flag_o !== 4'b1000) begin
            errors++;
            $display("FAIL dec_ovf got a1=%h f=%b required 7 1000", accum1_o, flag_o);
        end
        do_op(OP_LDI, 2'd1, 2'd0, 4'h0, lat, rl);
        do_op(OP_DEC, 2'd1, 2'd0, 4'd0, lat, rl);
        checks++;
        if (accum2_o !== 4'hF || flag_o !== 4'b0110) begin
            errors++;
            $display("FAIL dec_wrap got a2=%h f=%b required f 0110", accum2_o, flag_o);
        end
        do_op(OP_LDI, 2'd2, 2'd0, 4'h9, lat, rl);
        do_op(OP_SHL, 2'd2, 2'd0, 4'd0, lat, rl);
        checks++;
        if (accum3_o !== 4'h2 || flag_o !== 4'b0010) begin
            errors++;
            $display("FAIL shl got a3=%h f=%b required 2 0010", accum3_o, flag_o);
        end
        do_op(OP_NOP, 2'd2, 2'd0, 4'd0, lat, rl);
        checks++;
        if (lat !== 1 || flag_o !== 4'b0010 || accum3_o !== 4'h2) begin
            errors++;
            $display("FAIL nop got lat=%0d f=%b a3=%h required 1 0010 2", lat, flag_o, accum3_o);
        end
        do_op(OP_NOT, 2'd3, 2'd2, 4'd0, lat, rl);
        checks++;
        if (accum4_o !== 4'hD || flag_o !== 4'b0110) begin
            errors++;
            $display("FAIL not got a4=%h f=%b required d 0110", accum4_o, flag_o);
        end
    endtask

    task automatic test_halt;
        int lat, rl, nd;
        do_reset();
        do_op(OP_LDI, 2'd0, 2'd0, 4'd4, lat, rl);
        do_op(OP_HALT, 2'd0, 2'd0, 4'd0, lat, rl);
        checks++;
        if (lat !== 1 || halted !== 1'b1 || op_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL halt_enter got lat=%0d halted=%b ready=%b busy=%b required 1 1 0 0",
                     lat, halted, op_ready, busy);
        end
        @(negedge clk);
        op_code = OP_LDI; op_dst = 2'd0; op_imm = 4'hF; op_valid = 1'b1;
        nd = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) nd++;
        end
        op_valid = 1'b0;
        checks++;
        if (nd !== 0 || accum1_o !== 4'h4 || halted !== 1'b1) begin
            errors++;
            $display("FAIL halt_hold got dones=%0d a1=%h halted=%b required 0 4 1", nd, accum1_o, halted);
        end
        do_reset();
        @(posedge clk); #1;
        checks++;
        if (halted !== 1'b0 || op_ready !== 1'b1) begin
            errors++;
            $display("FAIL halt_clear got halted=%b ready=%b required 0 1", halted, op_ready);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_cmp();
        test_mul();
        test_back_to_back();
        test_reset_mid_mul();
        test_boundaries();
        test_halt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
